// File: rtl/accum_sequencer.sv
// Sequences an unsigned accumulation job over an external registered adder.
// Each operand takes one FETCH cycle to issue and one WAIT cycle to collect the sum.
module accum_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_add_en,
    output logic [DATA_W-1:0] o_add_a,
    output logic [DATA_W-1:0] o_add_b,
    input  logic [DATA_W:0]   i_add_sum,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_sat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LEN_W-1:0]    r_remaining;
    logic [DATA_W-1:0]   r_acc;
    logic                r_sat;

    logic                w_start_ok;
    logic                w_last;
    logic                w_carry;

    assign w_start_ok = i_start && (i_len != '0);
    assign w_last     = (r_remaining == LEN_W'(1));
    assign w_carry    = i_add_sum[DATA_W];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and adder handshake decode
    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_add_en    = 1'b0;
        o_add_a     = '0;
        o_add_b     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    o_add_en    = 1'b1;
                    o_add_a     = r_acc;
                    o_add_b     = i_in_data;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_state_nxt = w_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Job datapath: length counter, saturating accumulator, sticky saturation flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining <= '0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_remaining <= i_len;
                        r_acc       <= '0;
                        r_sat       <= 1'b0;
                    end
                end
                S_WAIT: begin
                    r_acc       <= w_carry ? {DATA_W{1'b1}} : i_add_sum[DATA_W-1:0];
                    r_sat       <= r_sat | w_carry;
                    r_remaining <= r_remaining - LEN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign o_out_valid = (r_state == S_DONE);
    assign o_out_data  = r_acc;
    assign o_busy      = (r_state != S_IDLE);
    assign o_sat       = r_sat;

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench for accum_sequencer: cycle-by-cycle vector table plus multi-cycle corner sequences.
module tb_accum_sequencer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 7;

    logic              clk;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              add_en;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W:0]   add_sum;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              busy;
    logic              sat;

    int checks   = 0;
    int failures = 0;
    int add_cnt  = 0;

    accum_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (start),
        .i_len      (len),
        .i_in_valid (in_valid),
        .i_in_data  (in_data),
        .o_in_ready (in_ready),
        .o_add_en   (add_en),
        .o_add_a    (add_a),
        .o_add_b    (add_b),
        .i_add_sum  (add_sum),
        .o_out_valid(out_valid),
        .o_out_data (out_data),
        .i_out_ready(out_ready),
        .o_busy     (busy),
        .o_sat      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered adder the sequencer drives, plus a count of issued adds
    initial add_sum = '0;
    always @(posedge clk) begin
        if (add_en) begin
            add_sum <= {1'b0, add_a} + {1'b0, add_b};
            add_cnt <= add_cnt + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic              rst;
        logic              start;
        logic [LEN_W-1:0]  len;
        logic              iv;
        logic [DATA_W-1:0] d;
        logic              ordy;
        logic              e_ir;
        logic              e_ae;
        logic [DATA_W-1:0] e_a;
        logic [DATA_W-1:0] e_b;
        logic              e_ov;
        logic [DATA_W-1:0] e_od;
        logic              e_busy;
        logic              e_sat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(int rst, int st, int ln, int iv, int d, int ordy,
                               int ir, int ae, int a, int b, int ov, int od, int bz, int st_sat);
        vec_t r;
        r.rst    = 1'(rst);
        r.start  = 1'(st);
        r.len    = LEN_W'(ln);
        r.iv     = 1'(iv);
        r.d      = DATA_W'(d);
        r.ordy   = 1'(ordy);
        r.e_ir   = 1'(ir);
        r.e_ae   = 1'(ae);
        r.e_a    = DATA_W'(a);
        r.e_b    = DATA_W'(b);
        r.e_ov   = 1'(ov);
        r.e_od   = DATA_W'(od);
        r.e_busy = 1'(bz);
        r.e_sat  = 1'(st_sat);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input int ln, input logic iv,
                         input int d, input logic ordy);
        reset     = rst;
        start     = st;
        len       = LEN_W'(ln);
        in_valid  = iv;
        in_data   = DATA_W'(d);
        out_ready = ordy;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Advance until out_valid or the cycle budget expires; an expired budget is a failed check
    task automatic wait_done(input string nm, input int limit, output int n);
        n = 0;
        #1;
        while (!out_valid && n < limit) begin
            step();
            #1;
            n = n + 1;
        end
        chk({nm, " out_valid reached"}, 32'(out_valid), 32'd1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " in_ready"},  32'(in_ready),  32'd0);
        chk({nm, " add_en"},    32'(add_en),    32'd0);
        chk({nm, " add_a"},     32'(add_a),     32'd0);
        chk({nm, " add_b"},     32'(add_b),     32'd0);
        chk({nm, " out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, " out_data"},  32'(out_data),  32'd0);
        chk({nm, " busy"},      32'(busy),      32'd0);
        chk({nm, " sat"},       32'(sat),       32'd0);
    endtask

    initial begin
        int n0;
        int n;

        // Reset first row overrides start; 10+20+30 job; 0xFFF0+0x0020 saturation with out_ready stall;
        // FFFF+1+3 keeps the accumulator pinned at all-ones while sat goes sticky.
        tbl.push_back(v(1,1,3,1,10,1,       0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,3,1,10,1,       0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,10,1,       1,1,0,10,0,0,1,0));
        tbl.push_back(v(0,0,0,1,20,1,       0,0,0,0,0,0,1,0));
        tbl.push_back(v(0,0,0,1,20,1,       1,1,10,20,0,10,1,0));
        tbl.push_back(v(0,0,0,1,30,1,       0,0,0,0,0,10,1,0));
        tbl.push_back(v(0,0,0,1,30,1,       1,1,30,30,0,30,1,0));
        tbl.push_back(v(0,0,0,0,0,1,        0,0,0,0,0,30,1,0));
        tbl.push_back(v(0,0,0,0,0,1,        0,0,0,0,1,60,1,0));
        tbl.push_back(v(0,0,0,0,0,1,        0,0,0,0,0,60,0,0));
        tbl.push_back(v(0,1,2,0,0,0,        0,0,0,0,0,60,0,0));
        tbl.push_back(v(0,0,0,1,'hFFF0,0,   1,1,0,'hFFF0,0,0,1,0));
        tbl.push_back(v(0,0,0,1,'h0020,0,   0,0,0,0,0,0,1,0));
        tbl.push_back(v(0,0,0,1,'h0020,0,   1,1,'hFFF0,'h0020,0,'hFFF0,1,0));
        tbl.push_back(v(0,0,0,0,0,0,        0,0,0,0,0,'hFFF0,1,0));
        tbl.push_back(v(0,0,0,0,0,0,        0,0,0,0,1,'hFFFF,1,1));
        tbl.push_back(v(0,0,0,0,0,1,        0,0,0,0,1,'hFFFF,1,1));
        tbl.push_back(v(0,0,0,0,0,0,        0,0,0,0,0,'hFFFF,0,1));
        tbl.push_back(v(0,1,3,0,0,1,        0,0,0,0,0,'hFFFF,0,1));
        tbl.push_back(v(0,0,0,1,'hFFFF,1,   1,1,0,'hFFFF,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,1,        0,0,0,0,0,0,1,0));
        tbl.push_back(v(0,0,0,1,1,1,        1,1,'hFFFF,1,0,'hFFFF,1,0));
        tbl.push_back(v(0,0,0,0,0,1,        0,0,0,0,0,'hFFFF,1,0));
        tbl.push_back(v(0,0,0,1,3,1,        1,1,'hFFFF,3,0,'hFFFF,1,1));
        tbl.push_back(v(0,0,0,0,0,1,        0,0,0,0,0,'hFFFF,1,1));
        tbl.push_back(v(0,0,0,0,0,1,        0,0,0,0,1,'hFFFF,1,1));
        tbl.push_back(v(0,0,0,0,0,1,        0,0,0,0,0,'hFFFF,0,1));

        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        step();

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].start, int'(tbl[i].len), tbl[i].iv, int'(tbl[i].d), tbl[i].ordy);
            #1;
            chk($sformatf("row%0d in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
            chk($sformatf("row%0d add_en", i),    32'(add_en),    32'(tbl[i].e_ae));
            chk($sformatf("row%0d add_a", i),     32'(add_a),     32'(tbl[i].e_a));
            chk($sformatf("row%0d add_b", i),     32'(add_b),     32'(tbl[i].e_b));
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("row%0d out_data", i),  32'(out_data),  32'(tbl[i].e_od));
            chk($sformatf("row%0d busy", i),      32'(busy),      32'(tbl[i].e_busy));
            chk($sformatf("row%0d sat", i),       32'(sat),       32'(tbl[i].e_sat));
            step();
        end

        // Operand stream stalls for 5 cycles between 7 and 8
        n0 = add_cnt;
        drive(1'b0, 1'b1, 2, 1'b0, 0, 1'b1);
        step();
        drive(1'b0, 1'b0, 0, 1'b1, 7, 1'b1);
        #1 chk("stall first add_en", 32'(add_en), 32'd1);
        step();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd1);
            chk($sformatf("stall%0d add_en", k),   32'(add_en),   32'd0);
            chk($sformatf("stall%0d busy", k),     32'(busy),     32'd1);
            step();
        end
        drive(1'b0, 1'b0, 0, 1'b1, 8, 1'b1);
        #1;
        chk("stall second add_a", 32'(add_a), 32'd7);
        chk("stall second add_b", 32'(add_b), 32'd8);
        step();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        wait_done("stall", 10, n);
        chk("stall out_data", 32'(out_data), 32'd15);
        chk("stall sat", 32'(sat), 32'd0);
        step();
        #1;
        chk("stall busy after", 32'(busy), 32'd0);
        chk("stall add count", 32'(add_cnt - n0), 32'd2);

        // Zero-length start is ignored; a start during a running job is ignored
        n0 = add_cnt;
        drive(1'b0, 1'b1, 0, 1'b1, 3, 1'b1);
        step();
        #1;
        chk("len0 busy", 32'(busy), 32'd0);
        chk("len0 in_ready", 32'(in_ready), 32'd0);
        chk("len0 add count", 32'(add_cnt - n0), 32'd0);
        drive(1'b0, 1'b1, 1, 1'b0, 0, 1'b0);
        step();
        drive(1'b0, 1'b1, 5, 1'b1, 5, 1'b0);
        #1;
        chk("restart add_en", 32'(add_en), 32'd1);
        chk("restart add_b", 32'(add_b), 32'd5);
        step();
        drive(1'b0, 1'b1, 5, 1'b0, 0, 1'b0);
        step();
        #1;
        chk("restart out_valid", 32'(out_valid), 32'd1);
        chk("restart out_data", 32'(out_data), 32'd5);
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        step();
        #1;
        chk("restart busy after", 32'(busy), 32'd0);
        chk("restart add count", 32'(add_cnt - n0), 32'd1);

        // Result held while out_ready is low for 4 cycles
        drive(1'b0, 1'b1, 1, 1'b0, 0, 1'b0);
        step();
        drive(1'b0, 1'b0, 0, 1'b1, 'h1234, 1'b0);
        step();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d out_data", k),  32'(out_data),  32'h1234);
            step();
        end
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        step();
        #1;
        chk("hold released busy", 32'(busy), 32'd0);
        chk("hold released out_data", 32'(out_data), 32'h1234);

        // Reset during WAIT of a len=4 job, then a fresh len=1 job
        drive(1'b0, 1'b1, 4, 1'b0, 0, 1'b1);
        step();
        drive(1'b0, 1'b0, 0, 1'b1, 100, 1'b1);
        step();
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
        step();
        drive(1'b0, 1'b0, 0, 1'b1, 50, 1'b1);
        #1 chk_all_zero("post-reset");
        step();
        drive(1'b0, 1'b1, 1, 1'b0, 0, 1'b1);
        step();
        drive(1'b0, 1'b0, 0, 1'b1, 9, 1'b1);
        step();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        wait_done("after-reset job", 10, n);
        chk("after-reset out_data", 32'(out_data), 32'd9);
        chk("after-reset sat", 32'(sat), 32'd0);
        step();

        // Maximum length: 127 ones, latency 2*127+1 from the start cycle
        n0 = add_cnt;
        drive(1'b0, 1'b1, 127, 1'b1, 1, 1'b1);
        step();
        drive(1'b0, 1'b0, 0, 1'b1, 1, 1'b1);
        wait_done("maxlen", 300, n);
        chk("maxlen latency", 32'(n + 1), 32'd255);
        chk("maxlen out_data", 32'(out_data), 32'd127);
        chk("maxlen add count", 32'(add_cnt - n0), 32'd127);
        step();
        #1 chk("maxlen busy after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accum_sequencer.md
ACCUM_SEQUENCER -- requirements
Module: accum_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, operand and accumulator width in bits.
REQ-002 Parameter LEN_W, default 7, width of the length field; maximum length 2^LEN_W - 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin an accumulation job.
REQ-006 len  input  LEN_W  number of operands in the job; sampled with start.
REQ-007 in_valid  input  1  operand stream valid.
REQ-008 in_data  input  DATA_W  unsigned operand.
REQ-009 in_ready  output  1  block accepts an operand this cycle.
REQ-010 add_en  output  1  enable to the shared registered adder.
REQ-011 add_a  output  DATA_W  adder operand A (current accumulator).
REQ-012 add_b  output  DATA_W  adder operand B (accepted operand).
REQ-013 add_sum  input  DATA_W+1  registered adder result, valid the cycle after add_en.
REQ-014 out_valid  output  1  accumulated result available.
REQ-015 out_data  output  DATA_W  accumulated (saturated) result.
REQ-016 out_ready  input  1  downstream accepts result.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 sat  output  1  at least one add in the current/last job saturated; valid with out_valid.

Function
REQ-019 FSM states IDLE, FETCH, WAIT, DONE; exactly one active.
REQ-020 IDLE: on start=1 and len!=0 -> FETCH; latch len into remaining counter; clear accumulator and sat to 0.
REQ-021 IDLE: start with len=0 is ignored; state remains IDLE, no output changes.
REQ-022 start asserted outside IDLE is ignored; no effect on the running job.
REQ-023 FETCH: in_ready=1; on in_valid=1, add_en=1 same cycle, add_a=accumulator, add_b=in_data; -> WAIT.
REQ-024 in_ready=0, add_en=0 in all states other than FETCH; add_a/add_b = 0 when add_en=0.
REQ-025 WAIT: accumulator <= add_sum[DATA_W-1:0] if add_sum[DATA_W]=0, else all-ones (saturate); sat <= sat | add_sum[DATA_W]; remaining decrements by 1.
REQ-026 WAIT: remaining=1 before decrement -> DONE; otherwise -> FETCH.
REQ-027 Throughput: 2 cycles minimum per operand; total job latency from start to out_valid = 2*len + 1 cycles with in_valid held high.
REQ-028 DONE: out_valid=1, out_data=accumulator, sat stable; on out_ready=1 -> IDLE same edge.
REQ-029 out_valid=0 outside DONE; out_data holds last accumulator value after leaving DONE until next job clears it.
REQ-030 FETCH with in_valid=0 stalls indefinitely with no state change.
REQ-031 Maximum len (2^LEN_W - 1) processed without counter wrap; remaining never underflows.
REQ-032 Arithmetic unsigned; saturated accumulator stays all-ones for remaining operands (add_sum carry again sets sat).

Reset
REQ-033 reset=1 at a rising edge forces IDLE, remaining=0, accumulator=0, sat=0 regardless of state, overriding start.
REQ-034 During/after reset: in_ready=0, add_en=0, add_a=0, add_b=0, out_valid=0, out_data=0, busy=0, sat=0.
REQ-035 Reset mid-job (FETCH/WAIT/DONE) abandons the job; an add_sum arriving the cycle after reset is ignored.

Verification
REQ-036 len=3, operands 10,20,30, in_valid high, out_ready high -> out_valid at cycle 7 after start, out_data=60, sat=0, busy low next cycle.
REQ-037 DATA_W=16, len=2, operands 0xFFF0,0x0020 -> out_data=0xFFFF, sat=1.
REQ-038 len=2, in_valid low 5 cycles between operands 7,8 -> in_ready held, out_data=15, no extra add_en pulses (exactly 2).
REQ-039 start with len=0 -> busy stays 0, no add_en; then start during FETCH of a len=1 job (operand 5) -> result 5, second start ignored.
REQ-040 out_ready low 4 cycles in DONE -> out_valid and out_data stable; reset asserted in WAIT of a len=4 job -> all outputs 0 next cycle, following len=1 job with operand 9 yields 9.
